// File: rtl/arb_requester.sv
// Client endpoint of the tree arbiter: buffers producer words and forwards them in bounded bursts while granted.
// Define ARB_REQ_TIMEOUT_EN to build the sticky starvation watchdog (starve output).
module arb_requester #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int BURST_MAX = 4,
  parameter int GAP_CYC   = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     req,
  input  logic                     gnt,
  output logic                     res_valid,
  output logic [DATA_W-1:0]        res_data,
  output logic                     res_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     starve
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_GAP} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [BW-1:0]       r_beat_cnt;
  logic [GW-1:0]       r_gap_cnt;
  logic                w_act;
  logic                w_push;
  logic                w_beat;
  logic                w_last;

  assign w_act    = (r_state == S_REQ) || (r_state == S_OWN);
  assign in_ready = !rst && (r_level != LW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_beat   = !rst && w_act && gnt && (r_level != '0);
  // A same-cycle push keeps the FIFO non-empty, so only the burst cap can end the tenure then.
  assign w_last   = w_beat && ((r_beat_cnt + BW'(1) == BW'(BURST_MAX)) ||
                               ((r_level == LW'(1)) && !w_push));

  assign res_data   = r_mem[r_rd_ptr];
  assign fifo_level = rst ? '0 : r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_beat) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_beat})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (r_level != '0) w_state_next = S_REQ;
      S_REQ:  if (w_beat) w_state_next = w_last ? S_GAP : S_OWN;
      S_OWN: begin
        if (!gnt)        w_state_next = S_REQ;
        else if (w_last) w_state_next = S_GAP;
      end
      S_GAP:  if (r_gap_cnt == GW'(GAP_CYC - 1)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req       = 1'b0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    if (!rst) begin
      req       = w_act;
      res_valid = w_beat;
      res_last  = w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_state_next == S_OWN) begin
      if (w_beat) r_beat_cnt <= r_beat_cnt + BW'(1);
    end else begin
      r_beat_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state != S_GAP)) r_gap_cnt <= '0;
    else                           r_gap_cnt <= r_gap_cnt + GW'(1);
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wait;
  logic          r_starve;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait   <= '0;
      r_starve <= 1'b0;
    end else if ((r_state == S_REQ) && !gnt) begin
      if (r_wait != TW'(TIMEOUT)) r_wait <= r_wait + TW'(1);
      if (r_wait == TW'(TIMEOUT - 1)) r_starve <= 1'b1;
    end else begin
      r_wait <= '0;
    end
  end

  assign starve = r_starve;
`else
  // Watchdog not built; TIMEOUT is only meaningful with it, so this is constant 0 for legal values.
  assign starve = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with random grants and resets.
module tb_arb_requester;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int BURST_MAX = 4;
  localparam int GAP_CYC   = 1;
  localparam int TIMEOUT   = 64;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              req;
  logic              gnt;
  logic              gnt_en;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_last;
  logic [LW-1:0]     fifo_level;
  logic              starve;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] cap_data[$];
  bit                cap_last[$];

  always #5 clk = ~clk;

  // The arbiter grants combinationally whenever this leaf requests and the bench allows it.
  assign gnt = req & gnt_en;

  arb_requester #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .req(req), .gnt(gnt), .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
    .fifo_level(fifo_level), .starve(starve)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, tenure described by request/beat-count/gap-remaining.
  initial begin : model
    logic [DATA_W-1:0] q[$];
    bit m_req, m_starve, e_req, g, e_beat, e_push, e_last;
    int m_burst, m_gap, m_wait, sz;
    m_req = 0; m_starve = 0; m_burst = 0; m_gap = 0; m_wait = 0;
    forever begin
      @(negedge clk);
      sz     = q.size();
      e_req  = !rst && m_req;
      g      = e_req && gnt_en;
      e_beat = g && (sz > 0);
      e_push = !rst && in_valid && (sz < DEPTH);
      e_last = e_beat && ((m_burst + 1 == BURST_MAX) || (sz == 1 && !e_push));
      chk("req", req, e_req);
      chk("in_ready", in_ready, !rst && (sz < DEPTH));
      chk("fifo_level", fifo_level, rst ? 0 : sz);
      chk("res_valid", res_valid, e_beat);
      chk("res_last", res_last, e_last);
      chk("starve", starve, m_starve);
      if (e_beat && res_valid) chk("res_data", res_data, q[0]);
      if (res_valid) begin
        cap_data.push_back(res_data);
        cap_last.push_back(res_last);
        $display("beat t=%0t data=0x%08h last=%0d level=%0d", $time, res_data, res_last, fifo_level);
      end
      if (rst) begin
        q.delete();
        m_req = 0; m_burst = 0; m_gap = 0; m_wait = 0; m_starve = 0;
      end else begin
`ifdef ARB_REQ_TIMEOUT_EN
        if (m_req && m_burst == 0 && !g) begin
          m_wait++;
          if (m_wait >= TIMEOUT) m_starve = 1;
        end else begin
          m_wait = 0;
        end
`endif
        if (e_beat) begin
          void'(q.pop_front());
          if (e_last) begin
            m_req = 0; m_burst = 0; m_gap = GAP_CYC;
          end else begin
            m_burst++;
          end
        end else if (m_req) begin
          m_burst = 0;
        end else if (m_gap > 0) begin
          m_gap--;
        end else if (sz > 0) begin
          m_req = 1;
        end
        if (e_push) q.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fifo_level == 0 && !req) && n < budget);
    chk(name, (fifo_level == 0 && !req), 1);
    step();
  endtask

  task automatic wait_req(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req && n < budget);
    chk(name, req, 1);
    step();
  endtask

  task automatic check_caps(input int base, input logic [DATA_W-1:0] ed[$], input bit el[$],
                            input string name);
    chk({name, "_count"}, cap_data.size() - base, ed.size());
    for (int i = 0; i < ed.size(); i++) begin
      if (base + i < cap_data.size()) begin
        chk($sformatf("%s_data%0d", name, i), cap_data[base + i], ed[i]);
        chk($sformatf("%s_last%0d", name, i), cap_last[base + i], el[i]);
      end
    end
  endtask

  initial begin : stim
    logic [DATA_W-1:0] ed[$];
    bit el[$];
    int base, acc, n, pv, pg;
    rst = 1; in_valid = 0; in_data = '0; gnt_en = 0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_in_ready", in_ready, 1);
    step();

    // Burst cap with gnt following req
    gnt_en = 1; base = cap_data.size();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = 32'hA0 + i;
      step();
    end
    in_valid = 0;
    wait_drain(80, "burst_drain");
    ed.delete(); el.delete();
    for (int i = 0; i < 6; i++) begin
      ed.push_back(32'hA0 + i);
      el.push_back(i == 3 || i == 5);
    end
    check_caps(base, ed, el, "burst");

    // Fill and backpressure
    gnt_en = 0; base = cap_data.size(); acc = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_data = 32'hC0 + i;
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    in_valid = 0;
    @(negedge clk);
    chk("fill_accepted", acc, 8);
    chk("fill_level", fifo_level, 8);
    chk("fill_in_ready", in_ready, 0);
    step();
    gnt_en = 1;
    @(negedge clk);
    chk("fill_first_pop", res_valid, 1);
    chk("fill_ready_same_cycle", in_ready, 0);
    @(negedge clk);
    chk("fill_ready_after_pop", in_ready, 1);
    step();
    wait_drain(80, "fill_drain");
    ed.delete(); el.delete();
    for (int i = 0; i < 8; i++) begin
      ed.push_back(32'hC0 + i);
      el.push_back(i == 3 || i == 7);
    end
    check_caps(base, ed, el, "fill");

    // Preemption after the first beat
    gnt_en = 0; base = cap_data.size();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 32'hD0 + i;
      step();
    end
    in_valid = 0;
    wait_req(20, "pre_req");
    gnt_en = 1; step();
    gnt_en = 0; step(); step();
    chk("pre_held_beats", cap_data.size() - base, 1);
    gnt_en = 1;
    wait_drain(40, "pre_drain");
    ed = '{32'hD0, 32'hD1, 32'hD2};
    el = '{0, 0, 1};
    check_caps(base, ed, el, "pre");

    // Push during the would-be final beat
    gnt_en = 0; base = cap_data.size();
    in_valid = 1; in_data = 32'hE0; step();
    in_valid = 0;
    wait_req(20, "push_last_req");
    gnt_en = 1; in_valid = 1; in_data = 32'hB1; step();
    in_valid = 0;
    wait_drain(40, "push_last_drain");
    ed = '{32'hE0, 32'hB1};
    el = '{0, 1};
    check_caps(base, ed, el, "push_last");

    // Starvation watchdog
    gnt_en = 0;
    in_valid = 1; in_data = 32'hF0; step();
    in_valid = 0;
`ifdef ARB_REQ_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (starve) break;
      if (req) n++;
    end
    chk("starve_delay", n, TIMEOUT);
    step();
    gnt_en = 1;
    wait_drain(20, "starve_drain");
    @(negedge clk);
    chk("starve_sticky", starve, 1);
    step();
    rst = 1; step();
    rst = 0;
    @(negedge clk);
    chk("starve_cleared", starve, 0);
    step();
`else
    repeat (70) step();
    @(negedge clk);
    chk("starve_off", starve, 0);
    step();
    gnt_en = 1;
    wait_drain(20, "starve_drain");
`endif

    // Randomized traffic, grants and occasional resets
    pv = 50; pg = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        pv = $urandom_range(10, 95);
        pg = $urandom_range(5, 100);
      end
      in_valid = ($urandom_range(0, 99) < pv);
      in_data  = $urandom;
      gnt_en   = ($urandom_range(0, 99) < pg);
      rst      = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 0; in_valid = 0; gnt_en = 1;
    wait_drain(100, "rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
